// File: rtl/pingpong_buffer_if.sv
// Handshake and read-port bundle between the ping-pong operand store and its
// producer, consumer and downstream 2-to-1 operand mux.
interface pingpong_buffer_if #(
    parameter int num_bits = 8
);
    logic                wr_valid;
    logic                wr_ready;
    logic [num_bits-1:0] wr_data;
    logic                rd_valid;
    logic                rd_ready;
    logic                rd_last;
    logic [num_bits-1:0] bank0_data;
    logic [num_bits-1:0] bank1_data;
    logic                sel;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_last, bank0_data, bank1_data, sel
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_last, bank0_data, bank1_data, sel
    );
endinterface

// File: rtl/pingpong_buffer.sv
// Double-buffered operand store: the producer fills one bank while the consumer
// drains the other, and both banks' words at the read index feed the operand mux.
module pingpong_buffer #(
    parameter int num_bits = 8,
    parameter int depth    = 4
) (
    input logic               clk,
    input logic               rst,
    pingpong_buffer_if.slave  bus
);
    localparam int idx_w = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(depth - 1);

    logic [num_bits-1:0] bank0 [depth];
    logic [num_bits-1:0] bank1 [depth];

    logic             wr_bank;
    logic             rd_bank;
    logic [idx_w-1:0] wr_idx;
    logic [idx_w-1:0] rd_idx;
    logic [1:0]       full;
    logic [1:0]       full_next;

    logic wr_ready;
    logic rd_valid;
    logic wr_fire;
    logic rd_fire;
    logic wr_at_last;
    logic rd_at_last;

    assign wr_ready   = !full[wr_bank];
    assign rd_valid   = full[rd_bank];
    assign wr_fire    = bus.wr_valid && wr_ready;
    assign rd_fire    = rd_valid && bus.rd_ready;
    assign wr_at_last = (wr_idx == last_idx);
    assign rd_at_last = (rd_idx == last_idx);

    // Writer and reader never hit the same bank in one cycle, so set and clear never collide.
    always_comb begin
        full_next = full;
        if (wr_fire && wr_at_last) begin
            full_next[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_at_last) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            full    <= 2'b00;
            for (int i = 0; i < depth; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            full <= full_next;

            if (wr_fire) begin
                if (wr_bank) begin
                    bank1[wr_idx] <= bus.wr_data;
                end else begin
                    bank0[wr_idx] <= bus.wr_data;
                end
                if (wr_at_last) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + idx_w'(1);
                end
            end

            if (rd_fire) begin
                if (rd_at_last) begin
                    rd_idx  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_idx <= rd_idx + idx_w'(1);
                end
            end
        end
    end

    // Every output comes straight from registers; no input reaches an output combinationally.
    assign bus.wr_ready   = wr_ready;
    assign bus.rd_valid   = rd_valid;
    assign bus.rd_last    = rd_valid && rd_at_last;
    assign bus.sel        = rd_bank;
    assign bus.bank0_data = bank0[rd_idx];
    assign bus.bank1_data = bank1[rd_idx];
endmodule
